// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: wait-FSM state codes,
// forwarding-select encodings and the register-match helper.
package hazard_unit_pkg;

  // Wait-FSM state encodings
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIV_WAIT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // E-stage forwarding selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // $0 is hard-wired to zero, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of datapath/controller signals exchanged with the hazard unit.
// The master side (datapath) drives register numbers and control bits;
// the slave side (hazard unit) returns forwarding selects, stalls and flushes.
interface hazard_unit_if;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       branchD;
  logic       divstartE;
  logic       memreqM, memackM;

  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM;
  logic       flushE;
  logic       divbusy;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divstartE, memreqM, memackM,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, flushE, divbusy
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divstartE, memreqM, memackM,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, flushE, divbusy
  );
endinterface

// File: rtl/hazard_wait_fsm.sv
// Multi-cycle wait tracker: holds the pipe while a divide runs and while a
// data-memory access waits for its acknowledge. The divide counter keeps
// running during a memory wait because the divider is independent of M.
module hazard_wait_fsm
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic divstartE,
  input  logic memreqM,
  input  logic memackM,
  output logic mem_wait,
  output logic div_wait,
  output logic divbusy
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mem_pending;
  logic             issue;

  assign mem_pending = memreqM & ~memackM;
  assign issue       = (state == ST_IDLE) & divstartE;

  // Counter loads on a divide issued from IDLE and otherwise counts down to 0 and holds
  always_comb begin
    cnt_next = cnt;
    if (issue)
      cnt_next = DIV_LOAD;
    else if ((state != ST_IDLE) && (cnt != '0))
      cnt_next = cnt - 1'b1;
  end

  // Next state: an unacknowledged memory request wins from any state; the divide ends when the counter reaches 0
  always_comb begin
    state_next = state;
    if (mem_pending)
      state_next = ST_MEM_WAIT;
    else begin
      case (state)
        ST_IDLE:     if (divstartE) state_next = ST_DIV_WAIT;
        ST_DIV_WAIT: if (cnt_next == '0) state_next = ST_IDLE;
        ST_MEM_WAIT: if (memackM) state_next = (cnt_next != '0) ? ST_DIV_WAIT : ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The acknowledge cycle itself completes the access, so it does not hold M
  assign mem_wait = ~memackM & (memreqM | (state == ST_MEM_WAIT));
  assign divbusy  = (state == ST_DIV_WAIT) | ((state == ST_MEM_WAIT) & (cnt != '0));
  assign div_wait = divbusy | issue;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard responder for the 5-stage MIPS core: forwarding selects,
// load-use and branch stalls, plus divide/memory wait stalls from the FSM.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  logic mem_wait, div_wait, busy;
  logic lw_stall, br_stall;

  hazard_wait_fsm #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .divstartE(hz.divstartE),
    .memreqM  (hz.memreqM),
    .memackM  (hz.memackM),
    .mem_wait (mem_wait),
    .div_wait (div_wait),
    .divbusy  (busy)
  );

  assign lw_stall = hz.memtoregE &
                    (reg_match(hz.rtE, hz.rsD) | reg_match(hz.rtE, hz.rtD));

  assign br_stall = hz.branchD &
                    ((hz.regwriteE & (reg_match(hz.rsD, hz.writeregE) | reg_match(hz.rtD, hz.writeregE))) |
                     (hz.memtoregM & (reg_match(hz.rsD, hz.writeregM) | reg_match(hz.rtD, hz.writeregM))));

  // Forwarding and stall outputs; everything is forced low while reset is asserted
  always_comb begin
    hz.forwardaE = FWD_RF;
    hz.forwardbE = FWD_RF;
    hz.forwardaD = 1'b0;
    hz.forwardbD = 1'b0;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.flushE    = 1'b0;
    hz.divbusy   = 1'b0;
    if (rst) begin
      if (hz.regwriteM && reg_match(hz.rsE, hz.writeregM))      hz.forwardaE = FWD_M;
      else if (hz.regwriteW && reg_match(hz.rsE, hz.writeregW)) hz.forwardaE = FWD_W;
      if (hz.regwriteM && reg_match(hz.rtE, hz.writeregM))      hz.forwardbE = FWD_M;
      else if (hz.regwriteW && reg_match(hz.rtE, hz.writeregW)) hz.forwardbE = FWD_W;
      hz.forwardaD = hz.regwriteM & reg_match(hz.rsD, hz.writeregM);
      hz.forwardbD = hz.regwriteM & reg_match(hz.rtD, hz.writeregM);
      hz.divbusy   = busy;
      if (mem_wait) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
      end else if (div_wait) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
      end else if (lw_stall || br_stall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: forwarding, load-use and branch
// stalls, divide wait, memory wait inside a divide, and mid-wait reset.
module tb_hazard_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_unit_if hz();

  hazard_unit #(
    .DIV_CYCLES(32),
    .CNT_W     (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0; hz.branchD = 1'b0;
    hz.divstartE = 1'b0; hz.memreqM = 1'b0; hz.memackM = 1'b0;
  endtask

  // Drive the wait-related inputs at the falling edge, then let the outputs settle
  task automatic applyStimulus(input logic div, input logic req, input logic ack);
    @(negedge clk);
    hz.divstartE = div;
    hz.memreqM   = req;
    hz.memackM   = ack;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clearInputs();
    rst = 1'b0;

    // Reset held with many inputs active: every output must stay 0
    @(negedge clk);
    hz.rsE = 5'd8; hz.rtE = 5'd8; hz.writeregM = 5'd8; hz.regwriteM = 1'b1;
    hz.rsD = 5'd8; hz.divstartE = 1'b1; hz.memreqM = 1'b1;
    #1;
    checkOutput("rst_forwardaE", 32'(hz.forwardaE), 32'd0);
    checkOutput("rst_forwardaD", 32'(hz.forwardaD), 32'd0);
    checkOutput("rst_stallF",    32'(hz.stallF),    32'd0);
    checkOutput("rst_stallM",    32'(hz.stallM),    32'd0);
    checkOutput("rst_divbusy",   32'(hz.divbusy),   32'd0);

    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    #1;
    checkOutput("idle_stallF", 32'(hz.stallF), 32'd0);

    // Forwarding: M has priority over W, then W alone, $0 never forwards
    clearInputs();
    hz.rsE = 5'd8; hz.rtE = 5'd8;
    hz.writeregM = 5'd8; hz.regwriteM = 1'b1;
    hz.writeregW = 5'd8; hz.regwriteW = 1'b1;
    hz.rsD = 5'd8; hz.rtD = 5'd3;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fwd_aE_M", 32'(hz.forwardaE), 32'd2);
    checkOutput("fwd_bE_M", 32'(hz.forwardbE), 32'd2);
    checkOutput("fwd_aD_M", 32'(hz.forwardaD), 32'd1);
    checkOutput("fwd_bD_no", 32'(hz.forwardbD), 32'd0);
    hz.regwriteM = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fwd_aE_W", 32'(hz.forwardaE), 32'd1);
    checkOutput("fwd_bE_W", 32'(hz.forwardbE), 32'd1);
    checkOutput("fwd_aD_off", 32'(hz.forwardaD), 32'd0);
    hz.rsE = 5'd0; hz.rtE = 5'd5; hz.writeregM = 5'd0; hz.regwriteM = 1'b1;
    hz.writeregW = 5'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fwd_aE_r0", 32'(hz.forwardaE), 32'd0);
    checkOutput("fwd_bE_none", 32'(hz.forwardbE), 32'd0);

    // Load-use stall for one cycle, then clear
    clearInputs();
    hz.memtoregE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lw_stallF", 32'(hz.stallF), 32'd1);
    checkOutput("lw_stallD", 32'(hz.stallD), 32'd1);
    checkOutput("lw_flushE", 32'(hz.flushE), 32'd1);
    checkOutput("lw_stallE", 32'(hz.stallE), 32'd0);
    hz.memtoregE = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lw_after_stallF", 32'(hz.stallF), 32'd0);
    checkOutput("lw_after_flushE", 32'(hz.flushE), 32'd0);
    hz.memtoregE = 1'b1; hz.rtE = 5'd0; hz.rsD = 5'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lw_r0_stallF", 32'(hz.stallF), 32'd0);

    // Branch stall on E ALU result, none when E writes $0, and on a load in M
    clearInputs();
    hz.branchD = 1'b1; hz.rsD = 5'd4; hz.regwriteE = 1'b1; hz.writeregE = 5'd4;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("br_stallF", 32'(hz.stallF), 32'd1);
    checkOutput("br_flushE", 32'(hz.flushE), 32'd1);
    hz.writeregE = 5'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("br_r0_stallF", 32'(hz.stallF), 32'd0);
    checkOutput("br_r0_flushE", 32'(hz.flushE), 32'd0);
    hz.regwriteE = 1'b0; hz.rtD = 5'd6; hz.memtoregM = 1'b1; hz.writeregM = 5'd6;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("br_ldM_stallD", 32'(hz.stallD), 32'd1);

    // Divide alone: F/D/E held exactly 32 cycles, M never held, re-issue while busy ignored
    clearInputs();
    for (int i = 0; i < 36; i++) begin
      applyStimulus(((i == 0) || (i == 10)) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("div_stallE_%0d", i), 32'(hz.stallE), 32'(i < 32));
      checkOutput($sformatf("div_stallF_%0d", i), 32'(hz.stallF), 32'(i < 32));
      checkOutput($sformatf("div_stallM_%0d", i), 32'(hz.stallM), 32'd0);
      checkOutput($sformatf("div_busy_%0d", i),   32'(hz.divbusy), 32'((i >= 1) && (i < 32)));
    end

    // Memory ack in the same cycle as the request costs nothing
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mem0_stallM", 32'(hz.stallM), 32'd0);
    checkOutput("mem0_stallF", 32'(hz.stallF), 32'd0);

    // Memory wait from idle: request at 0, ack at 2 gives two full stalls
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i <= 2) ? 1'b1 : 1'b0, (i == 2) ? 1'b1 : 1'b0);
      checkOutput($sformatf("mem_stallM_%0d", i), 32'(hz.stallM), 32'(i < 2));
      checkOutput($sformatf("mem_stallE_%0d", i), 32'(hz.stallE), 32'(i < 2));
      checkOutput($sformatf("mem_busy_%0d", i),   32'(hz.divbusy), 32'd0);
    end

    // Memory wait inside a divide: 3 full stalls, divide stall total still 32
    for (int i = 0; i < 36; i++) begin
      applyStimulus((i == 0) ? 1'b1 : 1'b0,
                    ((i >= 5) && (i <= 8)) ? 1'b1 : 1'b0,
                    (i == 8) ? 1'b1 : 1'b0);
      checkOutput($sformatf("dm_stallE_%0d", i), 32'(hz.stallE), 32'(i < 32));
      checkOutput($sformatf("dm_stallM_%0d", i), 32'(hz.stallM), 32'((i >= 5) && (i <= 7)));
      checkOutput($sformatf("dm_busy_%0d", i),   32'(hz.divbusy), 32'((i >= 1) && (i < 32)));
      checkOutput($sformatf("dm_flushE_%0d", i), 32'(hz.flushE), 32'd0);
    end

    // Reset in the middle of a divide wait drops outputs at once and leaves no residue
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_stallE", 32'(hz.stallE), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_stallE",  32'(hz.stallE),  32'd0);
    checkOutput("mid_rst_divbusy", 32'(hz.divbusy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_stallE",  32'(hz.stallE),  32'd0);
    checkOutput("post_rst_divbusy", 32'(hz.divbusy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst2_stallF", 32'(hz.stallF), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
